ntable_arbiter: RTL and testbench

Round-robin arbiter for the single read port of the node's neighbor table. Three requesters share the port: `reward` (packet-reward generation, req 0), `qtufmb` (Q-table update / best-hop selection, req 1) and `kch` (cluster-head tracking, req 2). The arbiter gives one requester tenure at a time, registers the granted table index and read strobe, and returns a per-requester read-valid aligned to the table's 1-cycle read latency. A watchdog revokes a tenure that runs too long.

---
 rtl/ntable_arbiter.sv | 156 +++++++++++++++
 tb/tb_ntable_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntable_arbiter.sv
// Round-robin arbiter for the neighbor table read port.
// Arbitrates reward (0), qtufmb (1) and kch (2), with a tenure watchdog and per-requester read return.
module ntable_arbiter #(
  parameter int IDX_WIDTH = 6,
  parameter int TIMEOUT   = 63
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [2:0]           req,
  input  logic [2:0]           rd_en,
  input  logic [IDX_WIDTH-1:0] idx_reward,
  input  logic [IDX_WIDTH-1:0] idx_qtufmb,
  input  logic [IDX_WIDTH-1:0] idx_kch,
  output logic [2:0]           gnt,
  output logic [IDX_WIDTH-1:0] table_idx,
  output logic                 table_rd,
  output logic [2:0]           rd_valid,
  output logic                 timeout_err,
  output logic                 busy
);

  typedef enum logic {IDLE, GRANT} arbStateT;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arbStateT             stateReg, stateNext;
  logic [2:0]           gntReg, gntNext;
  logic [1:0]           holderReg, holderNext;
  logic [1:0]           ptrReg, ptrNext;
  logic [2:0]           lockoutReg, lockoutNext;
  logic [2:0]           lockSet;
  logic [7:0]           cntReg, cntNext;
  logic [IDX_WIDTH-1:0] tableIdxReg, tableIdxNext;
  logic                 tableRdReg, tableRdNext;
  logic [2:0]           rdTagReg, rdTagNext;
  logic [2:0]           rdValidReg, rdValidNext;
  logic                 timeoutErrReg, timeoutErrNext;

  logic [2:0]           elig;
  logic [1:0]           scanIdx [3];
  logic [1:0]           pick;
  logic                 pickFound;
  logic [IDX_WIDTH-1:0] holderIdx;

  assign elig = req & ~lockoutReg;

  // scanIdx[n] is (ptr + n) mod 3; a lockout bit only survives while its request stays high
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gPerReq
      logic [2:0] scanSum;
      assign scanSum      = {1'b0, ptrReg} + 3'(gi);
      assign scanIdx[gi]  = (scanSum >= 3'd3) ? 2'(scanSum - 3'd3) : scanSum[1:0];
      assign lockoutNext[gi] = req[gi] & (lockoutReg[gi] | lockSet[gi]);
    end
  endgenerate

  always_comb begin
    case (holderReg)
      2'd0:    holderIdx = idx_reward;
      2'd1:    holderIdx = idx_qtufmb;
      default: holderIdx = idx_kch;
    endcase
  end

  always_comb begin
    pickFound = 1'b0;
    pick      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!pickFound && elig[scanIdx[i]]) begin
        pickFound = 1'b1;
        pick      = scanIdx[i];
      end
    end
  end

  always_comb begin
    stateNext      = stateReg;
    gntNext        = gntReg;
    holderNext     = holderReg;
    ptrNext        = ptrReg;
    cntNext        = cntReg;
    tableIdxNext   = tableIdxReg;
    tableRdNext    = 1'b0;
    rdTagNext      = rdTagReg;
    timeoutErrNext = 1'b0;
    lockSet        = 3'b000;
    // the return is tagged at issue time, so it survives the end of the tenure
    rdValidNext    = tableRdReg ? rdTagReg : 3'b000;

    case (stateReg)
      IDLE: begin
        if (pickFound) begin
          stateNext  = GRANT;
          holderNext = pick;
          gntNext    = 3'b001 << pick;
          ptrNext    = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          cntNext    = 8'd0;
        end
      end
      GRANT: begin
        cntNext = cntReg + 8'd1;
        if (rd_en[holderReg]) begin
          tableRdNext  = 1'b1;
          tableIdxNext = holderIdx;
          rdTagNext    = gntReg;
        end
        if (!req[holderReg]) begin
          stateNext = IDLE;
          gntNext   = 3'b000;
        end else if (cntReg == CNT_LAST) begin
          stateNext          = IDLE;
          gntNext            = 3'b000;
          timeoutErrNext     = 1'b1;
          lockSet[holderReg] = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stateReg      <= IDLE;
      gntReg        <= 3'b000;
      holderReg     <= 2'd0;
      ptrReg        <= 2'd0;
      lockoutReg    <= 3'b000;
      cntReg        <= 8'd0;
      tableIdxReg   <= '0;
      tableRdReg    <= 1'b0;
      rdTagReg      <= 3'b000;
      rdValidReg    <= 3'b000;
      timeoutErrReg <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      gntReg        <= gntNext;
      holderReg     <= holderNext;
      ptrReg        <= ptrNext;
      lockoutReg    <= lockoutNext;
      cntReg        <= cntNext;
      tableIdxReg   <= tableIdxNext;
      tableRdReg    <= tableRdNext;
      rdTagReg      <= rdTagNext;
      rdValidReg    <= rdValidNext;
      timeoutErrReg <= timeoutErrNext;
    end
  end

  assign gnt         = gntReg;
  assign table_idx   = tableIdxReg;
  assign table_rd    = tableRdReg;
  assign rd_valid    = rdValidReg;
  assign timeout_err = timeoutErrReg;
  assign busy        = (stateReg == GRANT);

endmodule

// File: tb/tb_ntable_arbiter.sv
// Self-checking bench for ntable_arbiter (TIMEOUT = 8); reads are scoreboarded from issue to rd_valid.
module tb_ntable_arbiter;
  localparam int IW = 6;

  typedef struct packed {
    logic [2:0]    tag;
    logic [IW-1:0] idx;
  } rdExpT;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [2:0]    rd_en = 3'b000;
  logic [IW-1:0] idx_reward = '0;
  logic [IW-1:0] idx_qtufmb = '0;
  logic [IW-1:0] idx_kch = '0;
  logic [2:0]    gnt;
  logic [IW-1:0] table_idx;
  logic          table_rd;
  logic [2:0]    rd_valid;
  logic          timeout_err;
  logic          busy;

  int total = 0;
  int bad = 0;

  rdExpT      expQ[$];
  rdExpT      expHead;
  logic       monOn = 1'b0;
  logic       nrstSampled = 1'b0;
  logic       pendValid = 1'b0;
  logic [2:0] pendTag = 3'b000;
  logic [2:0] expValid;

  ntable_arbiter #(.IDX_WIDTH(IW), .TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst), .req(req), .rd_en(rd_en),
    .idx_reward(idx_reward), .idx_qtufmb(idx_qtufmb), .idx_kch(idx_kch),
    .gnt(gnt), .table_idx(table_idx), .table_rd(table_rd), .rd_valid(rd_valid),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) nrstSampled <= nrst;

  // Read scoreboard: table_rd pops an expected read, rd_valid must follow one cycle later
  always @(negedge clk) begin
    if (monOn) begin
      expValid = (pendValid && nrstSampled) ? pendTag : 3'b000;
      total++;
      if (rd_valid !== expValid) begin
        bad++;
        $display("FAIL rd_valid: got %b expected %b", rd_valid, expValid);
      end else if (expValid != 3'b000) begin
        $display("read return tag=%b", rd_valid);
      end
      pendValid = 1'b0;
      if (table_rd === 1'b1) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL table_rd: got read idx=%0d expected no read", table_idx);
        end else begin
          expHead = expQ.pop_front();
          if (table_idx !== expHead.idx) begin
            bad++;
            $display("FAIL table_idx: got %0d expected %0d", table_idx, expHead.idx);
          end else begin
            $display("read issue tag=%b idx=%0d", expHead.tag, table_idx);
          end
          pendValid = 1'b1;
          pendTag   = expHead.tag;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0; req = 3'b000; rd_en = 3'b000;
    step(); step();
    monOn = 1'b1;
    total++;
    if ({gnt, table_idx, table_rd, rd_valid, timeout_err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b idx=%0d rd=%b val=%b err=%b busy=%b expected all 0",
               gnt, table_idx, table_rd, rd_valid, timeout_err, busy);
    end
    nrst = 1'b1;
  endtask

  task automatic test_single();
    req = 3'b001;
    step();
    total++;
    if (gnt !== 3'b001 || busy !== 1'b1) begin
      bad++; $display("FAIL single_grant: got gnt=%b busy=%b expected 001/1", gnt, busy);
    end
    rd_en = 3'b001; idx_reward = 6'd5; expQ.push_back('{tag: 3'b001, idx: 6'd5});
    step();
    rd_en = 3'b000;
    total++;
    if (table_rd !== 1'b1 || table_idx !== 6'd5) begin
      bad++; $display("FAIL single_read: got rd=%b idx=%0d expected 1/5", table_rd, table_idx);
    end
    step();
    req = 3'b000;
    total++;
    if (rd_valid !== 3'b001) begin
      bad++; $display("FAIL single_valid: got %b expected 001", rd_valid);
    end
    step();
    total++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      bad++; $display("FAIL single_release: got gnt=%b busy=%b expected 000/0", gnt, busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] order [3];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    nrst = 1'b0; step(); nrst = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        total++;
        if (gnt !== order[k] || busy !== 1'b1) begin
          bad++; $display("FAIL simul_grant%0d: got gnt=%b busy=%b expected %b/1", k, gnt, busy, order[k]);
        end
      end
      req = req & ~order[k];
      step();
      total++;
      if (gnt !== 3'b000 || busy !== 1'b0) begin
        bad++; $display("FAIL simul_bubble%0d: got gnt=%b busy=%b expected 000/0", k, gnt, busy);
      end
    end
  endtask

  task automatic test_fairness();
    logic [2:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b001; order[3] = 3'b010;
    req = 3'b011;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (gnt !== order[k]) begin
        bad++; $display("FAIL fair_grant%0d: got %b expected %b", k, gnt, order[k]);
      end
      step();
      req = req & ~order[k];
      step();
      req = 3'b011;
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_timeout();
    req = 3'b011;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (gnt !== 3'b001 || timeout_err !== 1'b0) begin
        bad++; $display("FAIL tmo_hold%0d: got gnt=%b err=%b expected 001/0", c, gnt, timeout_err);
      end
    end
    step();
    total++;
    if (gnt !== 3'b000 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL tmo_pulse: got gnt=%b err=%b expected 000/1", gnt, timeout_err);
    end
    step();
    total++;
    if (gnt !== 3'b010 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL tmo_next: got gnt=%b err=%b expected 010/0", gnt, timeout_err);
    end
    req = 3'b001;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (gnt !== 3'b000 || timeout_err !== 1'b0) begin
        bad++; $display("FAIL tmo_locked%0d: got gnt=%b err=%b expected 000/0", c, gnt, timeout_err);
      end
    end
    req = 3'b000;
    step();
    req = 3'b001;
    step();
    total++;
    if (gnt !== 3'b001) begin
      bad++; $display("FAIL tmo_regrant: got %b expected 001", gnt);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_foreign_late();
    req = 3'b010;
    step();
    total++;
    if (gnt !== 3'b010) begin
      bad++; $display("FAIL foreign_grant: got %b expected 010", gnt);
    end
    rd_en = 3'b001; idx_reward = 6'd7;
    step();
    total++;
    if (table_rd !== 1'b0) begin
      bad++; $display("FAIL foreign_strobe: got table_rd=%b expected 0", table_rd);
    end
    rd_en = 3'b010; idx_qtufmb = 6'd9; req = 3'b000;
    expQ.push_back('{tag: 3'b010, idx: 6'd9});
    step();
    rd_en = 3'b000;
    total++;
    if (gnt !== 3'b000 || table_rd !== 1'b1) begin
      bad++; $display("FAIL late_read: got gnt=%b rd=%b expected 000/1", gnt, table_rd);
    end
    step();
    total++;
    if (rd_valid !== 3'b010) begin
      bad++; $display("FAIL late_valid: got %b expected 010", rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    req = 3'b100;
    step();
    total++;
    if (gnt !== 3'b100) begin
      bad++; $display("FAIL b2b_grant: got %b expected 100", gnt);
    end
    for (int i = 1; i <= 4; i++) begin
      rd_en = 3'b100;
      idx_kch = 6'(i * 11);
      expQ.push_back('{tag: 3'b100, idx: 6'(i * 11)});
      step();
    end
    rd_en = 3'b000; req = 3'b000;
    step(); step();
  endtask

  task automatic test_reset_mid();
    req = 3'b010;
    step();
    total++;
    if (gnt !== 3'b010) begin
      bad++; $display("FAIL midrst_grant: got %b expected 010", gnt);
    end
    rd_en = 3'b010; idx_qtufmb = 6'd12;
    expQ.push_back('{tag: 3'b010, idx: 6'd12});
    step();
    rd_en = 3'b000; nrst = 1'b0;
    step();
    total++;
    if ({gnt, table_idx, table_rd, rd_valid, timeout_err, busy} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got gnt=%b idx=%0d rd=%b val=%b err=%b busy=%b expected all 0",
               gnt, table_idx, table_rd, rd_valid, timeout_err, busy);
    end
    nrst = 1'b1; req = 3'b110;
    step();
    total++;
    if (gnt !== 3'b010) begin
      bad++; $display("FAIL midrst_ptr: got %b expected 010", gnt);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_release_at_timeout();
    req = 3'b001;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (gnt !== 3'b001) begin
        bad++; $display("FAIL relwin_hold%0d: got %b expected 001", c, gnt);
      end
    end
    req = 3'b000;
    step();
    total++;
    if (gnt !== 3'b000 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL relwin_noerr: got gnt=%b err=%b expected 000/0", gnt, timeout_err);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_foreign_late();
    test_back_to_back();
    test_reset_mid();
    test_release_at_timeout();
    total++;
    if (expQ.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d outstanding reads expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
